// File: rtl/iir_pkg.sv
// Shared types and constants for the Q2.22 IIR datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iir_pkg;

    localparam int Q22_W = 24;
    localparam int ACC_W = 28;

    localparam logic [Q22_W-1:0] Q22_SAT_MAX = 24'h7FFFFF;
    localparam logic [Q22_W-1:0] Q22_SAT_MIN = 24'h800000;

    // Number of products per output sample.
    localparam logic [2:0] N_OPS = 3'd5;

    // Op index: the product currently presented to the multiplier.
    typedef enum logic [2:0] {
        OP_B0 = 3'd0,
        OP_B1 = 3'd1,
        OP_B2 = 3'd2,
        OP_A1 = 3'd3,
        OP_A2 = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

    // Shadow copy of the coefficients still needed after the handshake.
    // b0 is consumed by op0 on the handshake edge itself.
    typedef struct packed {
        logic [Q22_W-1:0] b1;
        logic [Q22_W-1:0] b2;
        logic [Q22_W-1:0] a1;
        logic [Q22_W-1:0] a2;
    } coef_sh_t;

    // Products from feedback taps (a1, a2) are subtracted.
    function automatic logic is_feedback(input logic [2:0] idx);
        return idx >= 3'd3;
    endfunction

endpackage

// File: rtl/q22_sat.sv
// Saturates a Q6.22 accumulator to Q2.22 and flags when clipping occurred.
// Latency: combinational.
// Backpressure: none.
module q22_sat
    import iir_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc,
    output logic [Q22_W-1:0]        q,
    output logic                    sat
);

    // Clip when the guard bits above the Q2.22 sign bit disagree with the sign.
    always_comb begin
        q   = acc[Q22_W-1:0];
        sat = 1'b0;
        if (acc[ACC_W-1:Q22_W-1] != {(ACC_W-Q22_W+1){acc[ACC_W-1]}}) begin
            sat = 1'b1;
            q   = acc[ACC_W-1] ? Q22_SAT_MIN : Q22_SAT_MAX;
        end
    end

endmodule

// File: rtl/iir_biquad_seq.sv
// Time-multiplexed DF-I biquad: issues 5 products to a shared multiplier, accumulates, saturates (optional sat_cnt via IIR_SAT_CNT_EN).
// Latency: handshake to y_valid is 7+MUL_LAT cycles; one sample per 7+MUL_LAT cycles.
// Backpressure: x_ready only in IDLE with clr low; multiplier has no stall, a missing product aborts via watchdog and sets err.
module iir_biquad_seq
    import iir_pkg::*;
#(
    parameter int MUL_LAT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [Q22_W-1:0]  x,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [Q22_W-1:0]  b0,
    input  logic [Q22_W-1:0]  b1,
    input  logic [Q22_W-1:0]  b2,
    input  logic [Q22_W-1:0]  a1,
    input  logic [Q22_W-1:0]  a2,
    input  logic              clr,
    output logic [Q22_W-1:0]  mul_a,
    output logic [Q22_W-1:0]  mul_b,
    output logic              mul_valid,
    input  logic [Q22_W-1:0]  mul_p,
    input  logic              mul_p_valid,
    output logic [Q22_W-1:0]  y,
    output logic              y_valid,
`ifdef IIR_SAT_CNT_EN
    output logic [15:0]       sat_cnt,
`endif
    output logic              err
);

    // Longest WAIT dwell (cycles after op4) before the sample is abandoned.
    localparam logic [7:0] WD_LIM = 8'(MUL_LAT + 4);

    state_e                  state;
    op_e                     op_idx;
    coef_sh_t                coef_sh;
    logic [Q22_W-1:0]        x_sh;
    logic [Q22_W-1:0]        x1, x2, y1, y2;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [2:0]              rcv_cnt;
    logic [7:0]              wait_cnt;
    logic                    clr_pend;
    logic [Q22_W-1:0]        sat_q;
    logic                    prod_take;
    logic                    prod_bad;
    logic                    last_prod;
`ifdef IIR_SAT_CNT_EN
    logic                    upd_sat;
`else
    logic                    unused_sat;
`endif

    assign x_ready = (state == ST_IDLE) && !clr;

    // Products are only expected while ops are in flight and not all received.
    assign prod_take = mul_p_valid && (state == ST_ISSUE || state == ST_WAIT) && (rcv_cnt < N_OPS);
    assign prod_bad  = mul_p_valid && !prod_take;
    assign last_prod = prod_take && (rcv_cnt == N_OPS - 3'd1);

    assign p_ext   = {{(ACC_W-Q22_W){mul_p[Q22_W-1]}}, mul_p};
    assign acc_nxt = is_feedback(rcv_cnt) ? (acc - p_ext) : (acc + p_ext);

    q22_sat u_sat (
        .acc (acc),
        .q   (sat_q),
`ifdef IIR_SAT_CNT_EN
        .sat (upd_sat)
`else
        .sat (unused_sat)
`endif
    );

    // Sequencer FSM: operand issue, product accumulation, history update, watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_idx    <= OP_B0;
            coef_sh   <= '0;
            x_sh      <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            acc       <= '0;
            rcv_cnt   <= '0;
            wait_cnt  <= '0;
            clr_pend  <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_valid <= 1'b0;
            y         <= '0;
            y_valid   <= 1'b0;
            err       <= 1'b0;
`ifdef IIR_SAT_CNT_EN
            sat_cnt   <= '0;
`endif
        end else begin
            y_valid <= 1'b0;
            if (prod_bad) err <= 1'b1;
            if (prod_take) begin
                acc     <= acc_nxt;
                rcv_cnt <= rcv_cnt + 3'd1;
            end
            if (clr && state != ST_IDLE) clr_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (clr) begin
                        x1 <= '0;
                        x2 <= '0;
                        y1 <= '0;
                        y2 <= '0;
`ifdef IIR_SAT_CNT_EN
                        sat_cnt <= '0;
`endif
                    end else if (x_valid) begin
                        x_sh      <= x;
                        coef_sh   <= '{b1: b1, b2: b2, a1: a1, a2: a2};
                        acc       <= '0;
                        rcv_cnt   <= '0;
                        mul_a     <= b0;
                        mul_b     <= x;
                        mul_valid <= 1'b1;
                        op_idx    <= OP_B0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    case (op_idx)
                        OP_B0: begin mul_a <= coef_sh.b1; mul_b <= x1; op_idx <= OP_B1; end
                        OP_B1: begin mul_a <= coef_sh.b2; mul_b <= x2; op_idx <= OP_B2; end
                        OP_B2: begin mul_a <= coef_sh.a1; mul_b <= y1; op_idx <= OP_A1; end
                        OP_A1: begin mul_a <= coef_sh.a2; mul_b <= y2; op_idx <= OP_A2; end
                        default: begin
                            mul_valid <= 1'b0;
                            wait_cnt  <= 8'd1;
                            state     <= ST_WAIT;
                        end
                    endcase
                end
                ST_WAIT: begin
                    if (last_prod) begin
                        state <= ST_UPDATE;
                    end else if (wait_cnt > WD_LIM) begin
                        // Abandon the sample; history and y stay as they were,
                        // and a deferred clear dies with the aborted sample.
                        err      <= 1'b1;
                        clr_pend <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    y       <= sat_q;
                    y_valid <= 1'b1;
                    if (clr_pend || clr) begin
                        x1 <= '0;
                        x2 <= '0;
                        y1 <= '0;
                        y2 <= '0;
                    end else begin
                        x2 <= x1;
                        x1 <= x_sh;
                        y2 <= y1;
                        y1 <= sat_q;
                    end
`ifdef IIR_SAT_CNT_EN
                    if (clr_pend || clr)
                        sat_cnt <= '0;
                    else if (upd_sat && sat_cnt != 16'hFFFF)
                        sat_cnt <= sat_cnt + 16'd1;
`endif
                    clr_pend <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Bench for iir_biquad_seq with a 6-stage saturating Q2.22 multiplier model.
// Latency: n/a.
// Backpressure: multiplier model can drop products or inject spurious ones.
module tb_iir_biquad_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] x, b0, b1, b2, a1, a2;
    logic        x_valid, x_ready, clr;
    logic [23:0] mul_a, mul_b, mul_p;
    logic        mul_valid, mul_p_valid;
    logic [23:0] y;
    logic        y_valid, err;
`ifdef IIR_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    logic        drop = 1'b0;
    logic        spur = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    iir_biquad_seq #(.MUL_LAT(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .b0          (b0),
        .b1          (b1),
        .b2          (b2),
        .a1          (a1),
        .a2          (a2),
        .clr         (clr),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_valid   (mul_valid),
        .mul_p       (mul_p),
        .mul_p_valid (mul_p_valid),
        .y           (y),
        .y_valid     (y_valid),
`ifdef IIR_SAT_CNT_EN
        .sat_cnt     (sat_cnt),
`endif
        .err         (err)
    );

    // Q2.22 multiply, saturating to the Q2.22 range.
    function automatic logic [23:0] qmul(input logic [23:0] a, input logic [23:0] b);
        logic signed [47:0] p;
        p = 48'($signed(a)) * 48'($signed(b));
        p = p >>> 22;
        if (p > 48'sh7FFFFF) return 24'h7FFFFF;
        if (p < -48'sh800000) return 24'h800000;
        return p[23:0];
    endfunction

    logic [23:0] pd [6];
    logic        pv [6];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
        end else begin
            pv[0] <= mul_valid;
            pd[0] <= qmul(mul_a, mul_b);
            for (int i = 1; i < 6; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
        end
    end

    assign mul_p       = pd[5];
    assign mul_p_valid = (pv[5] & ~drop) | spur;

    int          hs_q[$];
    logic [23:0] y_q[$];

    always @(negedge clk) begin
        if (x_valid && x_ready) hs_q.push_back(cyc);
        if (y_valid) y_q.push_back(y);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        clr_before;
        logic [23:0] x, b0, b1, b2, a1, a2;
        logic [23:0] exp_y;
        logic [15:0] exp_sat;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic [23:0] xv, input logic [23:0] c0,
                                input logic [23:0] c1, input logic [23:0] c2, input logic [23:0] f1,
                                input logic [23:0] f2, input logic [23:0] ey, input logic [15:0] es);
        vec_t v;
        v.clr_before = c; v.x = xv; v.b0 = c0; v.b1 = c1; v.b2 = c2;
        v.a1 = f1; v.a2 = f2; v.exp_y = ey; v.exp_sat = es;
        return v;
    endfunction

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic handshake(output int hs);
        hs = -1;
        x_valid = 1'b1;
        for (int k = 0; k < 40 && hs < 0; k++) begin
            @(negedge clk);
            if (x_ready) hs = cyc;
            @(posedge clk); #1;
        end
        x_valid = 1'b0;
        if (hs < 0) chk("handshake timeout", 0, 1);
    endtask

    task automatic do_sample(input vec_t v, input int clr_at, output logic [23:0] yv, output int lat);
        int hs;
        x = v.x; b0 = v.b0; b1 = v.b1; b2 = v.b2; a1 = v.a1; a2 = v.a2;
        handshake(hs);
        yv  = '0;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            clr = (k == clr_at);
            @(negedge clk);
            if (y_valid) begin lat = cyc - hs; yv = y; end
            @(posedge clk); #1;
        end
        clr = 1'b0;
        if (lat < 0) begin
            chk("y_valid timeout", 0, 1);
        end else begin
            @(negedge clk);
            chk("y_valid one-cycle", 32'(y_valid), 0);
            chk("y held", 32'(y), 32'(yv));
            @(posedge clk); #1;
        end
    endtask

    vec_t        tbl [15];
    logic [23:0] yv;
    int          lat;
    int          hs;

    initial begin
        rst = 1'b1; x_valid = 1'b0; clr = 1'b0;
        x = '0; b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;

        //            clr x        b0       b1       b2       a1       a2       y        sat
        tbl[0]  = mk(1, 24'h400000, 24'h400000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h400000, 0);
        tbl[1]  = mk(0, 24'h000000, 24'h400000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h000000, 0);
        tbl[2]  = mk(1, 24'h400000, 24'h400000, 24'h0, 24'h0, 24'hE00000, 24'h0, 24'h400000, 0);
        tbl[3]  = mk(0, 24'h000000, 24'h400000, 24'h0, 24'h0, 24'hE00000, 24'h0, 24'h200000, 0);
        tbl[4]  = mk(0, 24'h000000, 24'h400000, 24'h0, 24'h0, 24'hE00000, 24'h0, 24'h100000, 0);
        tbl[5]  = mk(1, 24'h600000, 24'h600000, 24'h600000, 24'h0, 24'h0, 24'h0, 24'h7FFFFF, 0);
        tbl[6]  = mk(0, 24'h600000, 24'h600000, 24'h600000, 24'h0, 24'h0, 24'h0, 24'h7FFFFF, 1);
        tbl[7]  = mk(1, 24'h600000, 24'hA00000, 24'hA00000, 24'h0, 24'h0, 24'h0, 24'h800000, 0);
        tbl[8]  = mk(0, 24'h600000, 24'hA00000, 24'hA00000, 24'h0, 24'h0, 24'h0, 24'h800000, 1);
        tbl[9]  = mk(1, 24'h400000, 24'h400000, 24'h200000, 24'h100000, 24'h0, 24'h0, 24'h400000, 0);
        tbl[10] = mk(0, 24'h000000, 24'h400000, 24'h200000, 24'h100000, 24'h0, 24'h0, 24'h200000, 0);
        tbl[11] = mk(0, 24'h000000, 24'h400000, 24'h200000, 24'h100000, 24'h0, 24'h0, 24'h100000, 0);
        tbl[12] = mk(1, 24'h400000, 24'h400000, 24'h0, 24'h0, 24'h0, 24'hC00000, 24'h400000, 0);
        tbl[13] = mk(0, 24'h000000, 24'h400000, 24'h0, 24'h0, 24'h0, 24'hC00000, 24'h000000, 0);
        tbl[14] = mk(0, 24'h000000, 24'h400000, 24'h0, 24'h0, 24'h0, 24'hC00000, 24'h400000, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset y", 32'(y), 0);
        chk("reset y_valid", 32'(y_valid), 0);
        chk("reset mul_valid", 32'(mul_valid), 0);
        chk("reset mul_a", 32'(mul_a), 0);
        chk("reset mul_b", 32'(mul_b), 0);
        chk("reset err", 32'(err), 0);
        chk("reset x_ready", 32'(x_ready), 1);
`ifdef IIR_SAT_CNT_EN
        chk("reset sat_cnt", 32'(sat_cnt), 0);
`endif
        @(posedge clk); #1;

        // Directed vector table: impulse, feedback, saturation, all taps
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].clr_before) pulse_clr();
            do_sample(tbl[i], -1, yv, lat);
            chk($sformatf("vec%0d y", i), 32'(yv), 32'(tbl[i].exp_y));
            chk($sformatf("vec%0d latency", i), 32'(lat), 13);
`ifdef IIR_SAT_CNT_EN
            chk($sformatf("vec%0d sat_cnt", i), 32'(sat_cnt), 32'(tbl[i].exp_sat));
`endif
        end

        // clr in cycle 3 of a sample: that sample is normal, history then zero
        pulse_clr();
        do_sample(mk(0, 24'h400000, 24'h400000, 24'h400000, 24'h0, 24'h0, 24'h0, 24'h0, 0), -1, yv, lat);
        chk("clr pre y", 32'(yv), 32'h400000);
        do_sample(mk(0, 24'h200000, 24'h400000, 24'h400000, 24'h0, 24'h0, 24'h0, 24'h0, 0), 3, yv, lat);
        chk("clr mid y", 32'(yv), 32'h600000);
        do_sample(mk(0, 24'h000000, 24'h400000, 24'h400000, 24'h400000, 24'h400000, 24'h400000, 24'h0, 0), -1, yv, lat);
        chk("clr post y", 32'(yv), 0);

        // Back-to-back samples, coefficient changed in cycle 2 of sample 0
        pulse_clr();
        hs_q.delete(); y_q.delete();
        x = 24'h400000; b0 = 24'h400000; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
        x_valid = 1'b1;
        for (int k = 0; k < 60 && hs_q.size() < 3; k++) begin
            @(negedge clk);
            @(posedge clk); #1;
            if (hs_q.size() >= 1 && cyc == hs_q[0] + 2) b0 = 24'h200000;
        end
        x_valid = 1'b0;
        for (int k = 0; k < 40 && y_q.size() < 3; k++) @(posedge clk);
        #1;
        chk("tput handshakes", 32'(hs_q.size()), 3);
        chk("tput outputs", 32'(y_q.size()), 3);
        if (hs_q.size() == 3 && y_q.size() == 3) begin
            chk("tput hs1 cycle", 32'(hs_q[1] - hs_q[0]), 13);
            chk("tput hs2 cycle", 32'(hs_q[2] - hs_q[0]), 26);
            chk("tput y0 shadow coef", 32'(y_q[0]), 32'h400000);
            chk("tput y1", 32'(y_q[1]), 32'h200000);
            chk("tput y2", 32'(y_q[2]), 32'h200000);
        end

        // Spurious product in IDLE
        @(posedge clk); #1;
        yv = y;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        chk("spurious err", 32'(err), 1);
        chk("spurious y unchanged", 32'(y), 32'(yv));
        chk("spurious no y_valid", 32'(y_valid), 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("err sticky", 32'(err), 1);

        // Reset clears err
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset2 err", 32'(err), 0);
        chk("reset2 y", 32'(y), 0);
        chk("reset2 x_ready", 32'(x_ready), 1);
        @(posedge clk); #1;

        // Watchdog: products withheld, abort after 11 cycles past op4
        begin
            int  err_cyc;
            logic yv_seen;
            logic rdy17;
            err_cyc = -1; yv_seen = 1'b0; rdy17 = 1'b0;
            drop = 1'b1;
            x = 24'h400000; b0 = 24'h400000; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
            handshake(hs);
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                if (err && err_cyc < 0) err_cyc = k;
                if (y_valid) yv_seen = 1'b1;
                if (k == 17) rdy17 = x_ready;
                @(posedge clk); #1;
            end
            drop = 1'b0;
            chk("watchdog err cycle", 32'(err_cyc), 17);
            chk("watchdog no y_valid", 32'(yv_seen), 0);
            chk("watchdog back to idle", 32'(rdy17), 1);
            chk("watchdog y unchanged", 32'(y), 0);
        end

        // History untouched by the aborted sample
        do_sample(mk(0, 24'h200000, 24'h400000, 24'h400000, 24'h0, 24'h0, 24'h0, 24'h0, 0), -1, yv, lat);
        chk("post-abort y", 32'(yv), 32'h200000);
        chk("post-abort latency", 32'(lat), 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
